// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one unified block memory between the i-cache and d-cache ports.
// Latency: a request seen in IDLE completes no earlier than 3 cycles later (IDLE, ISSUE, WAIT, then DONE).
// Backpressure: each port's BUSYWAIT stays high while its request is pending, until its own DONE cycle.
//
// Ports:
//   CLK, RESET                              clock; asynchronous active-high reset
//   I_READ, I_ADDRESS / I_READDATA, I_BUSYWAIT         i-cache block read port
//   D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA /
//     D_READDATA, D_BUSYWAIT                d-cache block read / write-back port
//   M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA /
//     M_READDATA, M_BUSYWAIT                initiator side toward the block memory
//
// Build option: ARB_ROUND_ROBIN_EN
//   undefined - fixed priority, the d-cache wins every tie.
//   defined   - a 1-bit last-grant flag (reset = I) makes ties alternate between the ports.
module memory_port_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_READ,
    input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
    output logic [DATA_WIDTH-1:0] I_READDATA,
    output logic                  I_BUSYWAIT,
    input  logic                  D_READ,
    input  logic                  D_WRITE,
    input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
    output logic [DATA_WIDTH-1:0] D_READDATA,
    output logic                  D_BUSYWAIT,
    output logic                  M_READ,
    output logic                  M_WRITE,
    output logic [ADDR_WIDTH-1:0] M_ADDRESS,
    output logic [DATA_WIDTH-1:0] M_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] M_READDATA,
    input  logic                  M_BUSYWAIT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                  r_own_i;
    logic                  r_own_d;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic w_i_pend;
    logic w_d_pend;
    logic w_pick_i;
    logic w_pick_d;
    logic w_grant;
    logic w_mem_act;
    logic w_owner_pend;
    logic w_capture;

    assign w_i_pend = I_READ;
    // A simultaneous read and write from the d-cache is a write-back.
    assign w_d_pend = D_READ | D_WRITE;

`ifdef ARB_ROUND_ROBIN_EN
    // r_last_d = 1 when the d-cache received the most recent grant.
    logic r_last_d;

    assign w_pick_d = w_d_pend & (~w_i_pend | ~r_last_d);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_last_d <= 1'b0;
        end else if (w_grant) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = w_d_pend;
`endif

    assign w_pick_i = w_i_pend & ~w_pick_d;
    assign w_grant  = (r_state == S_IDLE) & (w_i_pend | w_d_pend);

    // Data is only delivered if the owner is still asking for it; a request
    // withdrawn mid-access lets the memory finish but the block is dropped.
    assign w_owner_pend = (r_own_i & w_i_pend) | (r_own_d & w_d_pend);
    assign w_capture    = (r_state == S_WAIT) & ~M_BUSYWAIT & ~r_write & w_owner_pend;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_act   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_i_pend | w_d_pend) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The memory raises BUSYWAIT one edge late, so it is not looked at here.
                w_mem_act   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_mem_act = 1'b1;
                if (!M_BUSYWAIT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping: the winner's address, op and data are frozen here so
    // later changes on the cache side during the access have no effect.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_own_i <= 1'b0;
            r_own_d <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_own_i <= w_pick_i;
            r_own_d <= w_pick_d;
            r_write <= w_pick_d & D_WRITE;
            r_addr  <= w_pick_d ? D_ADDRESS : I_ADDRESS;
            r_wdata <= w_pick_d ? D_WRITEDATA : '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (w_capture) begin
            if (r_own_i) begin
                r_i_rdata <= M_READDATA;
            end
            if (r_own_d) begin
                r_d_rdata <= M_READDATA;
            end
        end
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset removes them without waiting for a clock edge.
    assign M_READ      = w_mem_act & ~r_write;
    assign M_WRITE     = w_mem_act & r_write;
    assign M_ADDRESS   = r_addr;
    assign M_WRITEDATA = r_wdata;

    assign I_READDATA = r_i_rdata;
    assign D_READDATA = r_d_rdata;

    assign I_BUSYWAIT = w_i_pend & ~((r_state == S_DONE) & r_own_i);
    assign D_BUSYWAIT = w_d_pend & ~((r_state == S_DONE) & r_own_d);

endmodule
